rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (regd/regWrite/dataWrite) between two writeback requesters.
//  The requesters are the ALU writeback and the memory (load) writeback.
//  - Fixed priority to memory, with a starvation guard that forces an ALU grant.
//  - Registered output stage; sits between the execute/memory stages and register_file.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_wb_starve_ctr.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants, writeback source codes and the
// writeback arbiter state encoding.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_wb_starve_ctr.sv
// Saturating count of consecutive cycles the ALU request was denied; hit
// flags that the count about to be stored reaches STARVE_LIMIT.
module rf_wb_starve_ctr
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign hit = (cnt_nxt == LIMIT);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU and load
// writeback: memory first, with a starvation-forced ALU grant, registered output.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W       = REG_DATA_W,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] regd,
  output logic              regWrite,
  output logic [DATA_W-1:0] dataWrite,
  output logic              wb_src,
  output logic              forced
);

  arb_state_e state, state_nxt;

  logic              hit;
  logic              forced_grant;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              wr_src;

  // PRI_ALU only differs by letting a pending ALU request jump ahead of memory.
  always_comb begin
    alu_ready    = 1'b0;
    mem_ready    = 1'b0;
    forced_grant = 1'b0;
    if (reset) begin
      if ((state == PRI_ALU) && alu_valid) begin
        alu_ready    = 1'b1;
        forced_grant = 1'b1;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = PRI_MEM;
    if ((state == PRI_MEM) && hit) begin
      state_nxt = PRI_ALU;
    end
  end

  // Register 0 is hardwired: the transfer completes but no write is issued.
  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = mem_rd;
    wr_data = mem_data;
    wr_src  = WB_SRC_MEM;
    if (mem_valid && mem_ready) begin
      wr_en = (mem_rd != '0);
    end else if (alu_valid && alu_ready) begin
      wr_en   = (alu_rd != '0);
      wr_rd   = alu_rd;
      wr_data = alu_data;
      wr_src  = WB_SRC_ALU;
    end
  end

  rf_wb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk  (clk),
    .reset(reset),
    .inc  (alu_valid && !alu_ready),
    .clr  (!alu_valid || alu_ready),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= PRI_MEM;
      regd      <= '0;
      regWrite  <= 1'b0;
      dataWrite <= '0;
      wb_src    <= WB_SRC_ALU;
      forced    <= 1'b0;
    end else begin
      state    <= state_nxt;
      regWrite <= wr_en;
      if (wr_en) begin
        regd      <= wr_rd;
        dataWrite <= wr_data;
        wb_src    <= wr_src;
        forced    <= forced_grant;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench: the driver pushes expected writebacks into a queue,
// a monitor pops and compares whenever regWrite is presented.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic [4:0]  regd;
  logic        regWrite;
  logic [31:0] dataWrite;
  logic        wb_src, forced;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        src;
    logic        frc;
  } wb_t;

  wb_t         exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] regs[32];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .mem_ready(mem_ready),
    .regd     (regd),
    .regWrite (regWrite),
    .dataWrite(dataWrite),
    .wb_src   (wb_src),
    .forced   (forced)
  );

  // Behavioural register file fed by the DUT's write port.
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) if (regWrite && (regd != 5'd0)) regs[regd] <= dataWrite;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_regWrite"},  {31'd0, regWrite}, 32'd0);
    check({tag, "_regd"},      {27'd0, regd},     32'd0);
    check({tag, "_dataWrite"}, dataWrite,         32'd0);
    check({tag, "_wb_src"},    {31'd0, wb_src},   32'd0);
    check({tag, "_forced"},    {31'd0, forced},   32'd0);
  endtask

  // One cycle of stimulus with the hand-derived grant for that cycle.
  task automatic step(input logic rst, input logic mv, input logic [4:0] mrd,
                      input logic [31:0] md, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic emr, input logic ear,
                      input logic efor);
    @(negedge clk);
    reset     = rst;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    #1;
    check("mem_ready", {31'd0, mem_ready}, {31'd0, emr});
    check("alu_ready", {31'd0, alu_ready}, {31'd0, ear});
    if (emr && (mrd != 5'd0)) exp_q.push_back('{rd: mrd, data: md, src: WB_SRC_MEM, frc: 1'b0});
    if (ear && (ard != 5'd0)) exp_q.push_back('{rd: ard, data: ad, src: WB_SRC_ALU, frc: efor});
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every presented write must match the oldest expected one.
  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (regWrite) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", regd, dataWrite);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd",     {27'd0, regd},   {27'd0, e.rd});
          check("wb_data",   dataWrite,       e.data);
          check("wb_src",    {31'd0, wb_src}, {31'd0, e.src});
          check("wb_forced", {31'd0, forced}, {31'd0, e.frc});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int j;
    logic ag;

    // 1: reset held with both requesters valid
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0);
      check_zero("reset_hold");
    end
    step(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0);

    // 2: ALU alone
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    check("regfile_r5", regs[5], 32'h1234);
    check("regfile_r3", regs[3], 32'h33);

    // 3: continuous contention: MEM x4 then forced ALU, twice
    k = 0;
    j = 0;
    for (int i = 0; i < 10; i++) begin
      ag = ((i % 5) == 4);
      step(1'b1, 1'b1, 5'd10, 32'h100 + k, 1'b1, 5'd11, 32'h200 + j, !ag, ag, ag);
      if (ag) j++;
      else k++;
    end

    // 4: load to r0 completes but never writes
    step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle();
    check("r0_regWrite", {31'd0, regWrite}, 32'd0);
    idle();
    check("regfile_r0", regs[0], 32'd0);

    // 5: same destination on both sides
    step(1'b1, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB, 1'b0, 1'b1, 1'b0);
    idle();
    check("regfile_r7_first", regs[7], 32'hA);
    idle();
    check("regfile_r7_second", regs[7], 32'hB);

    // 6a: reset right after an accepted ALU write
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check_zero("reset_mid");

    // 6b: reset while PRI_ALU is pending restarts the starvation count
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 5'd12, 32'h300 + i, 1'b1, 5'd13, 32'h400, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd12, 32'h304, 1'b1, 5'd13, 32'h400, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd12, 32'h304, 1'b1, 5'd13, 32'h400, 1'b0, 1'b0, 1'b0);
    check_zero("reset_pri_alu");
    for (int i = 0; i < 5; i++) begin
      ag = (i == 4);
      step(1'b1, 1'b1, 5'd12, 32'h304 + i, 1'b1, 5'd13, 32'h400, !ag, ag, ag);
    end

    idle();
    idle();
    idle();
    check("pending_writes", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
